apb_master_8bit: RTL and testbench

- APB initiator that turns single-word command requests into APB transfers.
- Drives one APB completer port, such as an 8-bit timer/counter register file.
- Replaces hand-timed psel/penable/pwrite sequencing in benches and in the upcoming control sequencer.
- One transfer in flight at a time; each transfer returns a one-cycle response with read data and the error flag.

---
 rtl/apb_master_8bit_if.sv | 35 +++
 rtl/apb_master_8bit.sv | 79 +++++++
 tb/tb_apb_master_8bit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_8bit_if.sv
// apb_master_8bit_if: command/response handshake plus APB completer bus for apb_master_8bit.
interface apb_master_8bit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_8bit.sv
// apb_master_8bit: single-outstanding APB initiator turning commands into SETUP/ACCESS transfers.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_8bit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic pclk,
    input logic preset_n,
    apb_master_8bit_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state;
    logic   expired;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign bus.cmd_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign expired = (wait_cnt == 8'(TIMEOUT_CYCLES)) && !bus.pready;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)
            wait_cnt <= '0;
        else if (state == SETUP)
            wait_cnt <= '0;
        else if (state == ACCESS && !bus.pready)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state           <= IDLE;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    state      <= SETUP;
                    bus.psel   <= 1'b1;
                    bus.pwrite <= bus.cmd_write;
                    bus.paddr  <= bus.cmd_addr;
                    if (bus.cmd_write)
                        bus.pwdata <= bus.cmd_wdata;
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: if (bus.pready || expired) begin
                    // a real pready on the expiry edge wins over the timeout
                    state           <= IDLE;
                    bus.psel        <= 1'b0;
                    bus.penable     <= 1'b0;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_err     <= bus.pready ? bus.pslverr : 1'b1;
                    bus.rsp_timeout <= !bus.pready;
                    bus.rsp_rdata   <= (bus.pready && !bus.pwrite) ? bus.prdata : '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_8bit.sv
// tb_apb_master_8bit: randomized requester/completer bench with a transaction-level reference model.
module tb_apb_master_8bit;
    localparam int TO = 4;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [2:0] m_addr = '0;
    logic       m_write = 1'b0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_rdata = '0;
    logic       m_err = 1'b0;
    logic       m_timeout = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_8bit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    apb_master_8bit #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag);
        check({tag, "_paddr"}, 32'(bus.paddr), 32'(m_addr));
        check({tag, "_pwrite"}, 32'(bus.pwrite), 32'(m_write));
        check({tag, "_pwdata"}, 32'(bus.pwdata), 32'(m_wdata));
    endtask

    task automatic check_rsp_held(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(m_rdata));
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(m_err));
        check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(m_timeout));
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            @(negedge pclk);
            check("idle_psel", 32'(bus.psel), 0);
            check("idle_penable", 32'(bus.penable), 0);
            check("idle_ready", 32'(bus.cmd_ready), 1);
            check_rsp_held("idle");
            check_bus("idle");
        end
    endtask

    // Called at a negedge with the master idle; returns at the negedge of the response cycle.
    task automatic txn(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input int waits, input logic err, input logic [7:0] rd);
        int n;
        bit to;
        n = waits;
        to = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (waits > TO) begin
            n = TO;
            to = 1'b1;
        end
`endif
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr = a;
        bus.cmd_wdata = d;
        check("accept_ready", 32'(bus.cmd_ready), 1);
        m_addr = a;
        m_write = w;
        if (w) m_wdata = d;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr = 3'($urandom);
        bus.cmd_wdata = 8'($urandom);
        bus.pready = 1'b0;
        bus.prdata = 8'($urandom);
        bus.pslverr = 1'($urandom);
        check("setup_psel", 32'(bus.psel), 1);
        check("setup_penable", 32'(bus.penable), 0);
        check("setup_ready", 32'(bus.cmd_ready), 0);
        check_rsp_held("setup");
        check_bus("setup");
        for (int i = 0; i <= n; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            check("access_psel", 32'(bus.psel), 1);
            check("access_penable", 32'(bus.penable), 1);
            check("access_ready", 32'(bus.cmd_ready), 0);
            check_rsp_held("access");
            check_bus("access");
            bus.pready = (i == waits);
            bus.prdata = (i == waits) ? rd : 8'($urandom);
            bus.pslverr = (i == waits) ? err : 1'($urandom);
        end
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        m_timeout = to;
        m_err = to | err;
        m_rdata = (to || w) ? 8'h00 : rd;
        check("rsp_valid", 32'(bus.rsp_valid), 1);
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_timeout));
        check("rsp_psel", 32'(bus.psel), 0);
        check("rsp_penable", 32'(bus.penable), 0);
        check("rsp_ready", 32'(bus.cmd_ready), 1);
        check_bus("rsp");
        bus.pready = 1'($urandom);
        bus.prdata = 8'($urandom);
        bus.pslverr = 1'($urandom);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = '0;
        bus.prdata = '0;
        bus.pready = 1'b0;
        bus.pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        check("reset_ready", 32'(bus.cmd_ready), 1);
        check("reset_psel", 32'(bus.psel), 0);
        check("reset_penable", 32'(bus.penable), 0);
        check_rsp_held("reset");
        check_bus("reset");
        preset_n = 1'b1;
        idle(1);

        txn(1'b1, 3'b010, 8'h5A, 0, 1'b0, 8'hC3);
        idle(1);
        txn(1'b0, 3'b011, 8'h00, 2, 1'b0, 8'hA2);
        idle(2);
        txn(1'b1, 3'b111, 8'h33, 0, 1'b1, 8'h00);
        txn(1'b0, 3'b001, 8'h44, 1, 1'b0, 8'h5C);
        idle(1);
        for (int k = 0; k < 4; k++)
            txn(1'b1, 3'(k), 8'h10 + 8'(k), 0, 1'b0, 8'($urandom));
        idle(1);

        repeat (40) begin
            txn(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

`ifdef APB_TIMEOUT_EN
        txn(1'b0, 3'b100, 8'h00, TO + 2, 1'b0, 8'h77);
        idle(1);
        txn(1'b0, 3'b100, 8'h00, TO, 1'b0, 8'h77);
        idle(1);
`endif

        txn(1'b1, 3'b110, 8'hE7, 0, 1'b1, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = 3'b101;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.pready = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check("pre_reset_penable", 32'(bus.penable), 1);
        #2 preset_n = 1'b0;
        #1;
        m_addr = '0;
        m_write = 1'b0;
        m_wdata = '0;
        m_rdata = '0;
        m_err = 1'b0;
        m_timeout = 1'b0;
        check("abort_psel", 32'(bus.psel), 0);
        check("abort_penable", 32'(bus.penable), 0);
        check("abort_ready", 32'(bus.cmd_ready), 1);
        check_rsp_held("abort");
        check_bus("abort");
        bus.pready = 1'b1;
        bus.prdata = 8'hEE;
        bus.pslverr = 1'b1;
        @(negedge pclk);
        preset_n = 1'b1;
        idle(4);
        txn(1'b0, 3'b010, 8'h00, 1, 1'b0, 8'h96);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
